// File: rtl/tenyr_bus_pkg.sv
// Shared constants and types for the tenyr bus memory responder.
package tenyr_bus_pkg;
  localparam int          WORD_W       = 32;
  localparam int          ERR_W        = 8;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;

  typedef enum logic {CLEAR, RUN} resp_state_t;
endpackage

// File: rtl/tenyr_dpram.sv
// DEPTH x WORD_W dual-port RAM: port A read/write, port B read-only.
// Registered reads, no reset, no write-to-read bypass between ports.
import tenyr_bus_pkg::*;

module tenyr_dpram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [WORD_W-1:0] wdata_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [AW-1:0]     addr_b,
  output logic [WORD_W-1:0] rdata_b
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    else if (re_a) rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end
endmodule

// File: rtl/tenyr_mem_responder.sv
// Word-addressed memory responder for the tenyr fetch and load/store ports:
// post-reset clear, window decode, write-first fetch bypass, sticky errors.
import tenyr_bus_pkg::*;

module tenyr_mem_responder #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          DEPTH = 1024,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [31:0] FILL  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       insn_addr,
  output logic [WORD_W-1:0] insn_data,
  input  logic              norm_en,
  input  logic              rw,
  input  logic [31:0]       norm_addr,
  input  logic [WORD_W-1:0] norm_wdata,
  output logic [WORD_W-1:0] norm_rdata,
  output logic              ready,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);
  resp_state_t       state, state_nx;
  logic [AW-1:0]     clr_idx, clr_idx_nx;
  logic              run;
  logic [31:0]       insn_off, norm_off;
  logic              insn_hit, norm_hit;
  logic [AW-1:0]     insn_idx, norm_idx;
  logic              norm_wr, norm_rd, bypass;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata_a, ram_rdata_b;
  logic [1:0]        miss_cnt;
  logic [ERR_W:0]    cnt_sum;
  logic              insn_sel_mem, insn_sel_byp, norm_sel_mem;
  logic [WORD_W-1:0] byp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) state_nx = RUN;
      end
      RUN: state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  assign run = (state == RUN);

  // Wrap-around subtraction makes addresses below BASE land far out of window.
  assign insn_off = insn_addr - BASE;
  assign norm_off = norm_addr - BASE;
  assign insn_hit = insn_off < 32'(DEPTH);
  assign norm_hit = norm_off < 32'(DEPTH);
  assign insn_idx = insn_off[AW-1:0];
  assign norm_idx = norm_off[AW-1:0];

  assign norm_wr   = run & norm_en & rw & norm_hit;
  assign norm_rd   = run & norm_en & ~rw & norm_hit;
  assign bypass    = norm_wr & insn_hit & (norm_idx == insn_idx);
  assign ram_we    = ~run | norm_wr;
  assign ram_addr  = run ? norm_idx : clr_idx;
  assign ram_wdata = run ? norm_wdata : FILL;

  tenyr_dpram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_a    (ram_we),
    .re_a    (norm_rd),
    .addr_a  (ram_addr),
    .wdata_a (ram_wdata),
    .rdata_a (ram_rdata_a),
    .addr_b  (insn_idx),
    .rdata_b (ram_rdata_b)
  );

  assign miss_cnt = {1'b0, run & ~insn_hit} + {1'b0, run & norm_en & ~norm_hit};
  assign cnt_sum  = {1'b0, err_count} + (ERR_W + 1)'(miss_cnt);

  // Output selects are registered alongside the RAM read so reset/miss/clear
  // force zero without resetting the RAM's own data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insn_sel_mem <= 1'b0;
      insn_sel_byp <= 1'b0;
      byp_data     <= '0;
      norm_sel_mem <= 1'b0;
      ready        <= 1'b0;
      err          <= 1'b0;
      err_count    <= '0;
    end else begin
      insn_sel_mem <= run & insn_hit & ~bypass;
      insn_sel_byp <= bypass;
      if (bypass) byp_data <= norm_wdata;
      if (!run) norm_sel_mem <= 1'b0;
      else if (norm_en && !rw) norm_sel_mem <= norm_hit;
      ready <= run;
      if (miss_cnt != 2'd0) err <= 1'b1;
      err_count <= cnt_sum[ERR_W] ? {ERR_W{1'b1}} : cnt_sum[ERR_W-1:0];
    end
  end

  assign insn_data  = insn_sel_byp ? byp_data : (insn_sel_mem ? ram_rdata_b : '0);
  assign norm_rdata = norm_sel_mem ? ram_rdata_a : '0;
endmodule

// File: tb/tb_tenyr_mem_responder.sv
// Self-checking bench for tenyr_mem_responder against a behavioural memory model.
module tb_tenyr_mem_responder;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 16;
  localparam logic [31:0] FILL  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn_addr = BASE;
  logic [31:0] insn_data;
  logic        norm_en = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] norm_addr = BASE;
  logic [31:0] norm_wdata = '0;
  logic [31:0] norm_rdata;
  logic        ready, err;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_insn, m_norm;
  logic        m_err;
  int          m_cnt;

  tenyr_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk(clk), .reset(reset), .insn_addr(insn_addr), .insn_data(insn_data),
    .norm_en(norm_en), .rw(rw), .norm_addr(norm_addr), .norm_wdata(norm_wdata),
    .norm_rdata(norm_rdata), .ready(ready), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off % DEPTH);
  endfunction

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
    m_norm = '0; m_insn = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Apply one cycle of requests (in RUN) at a negedge, then advance to the
  // next negedge and update the reference model.
  task automatic step(input logic [31:0] ia, input logic en, input logic w,
                      input logic [31:0] na, input logic [31:0] wd);
    int misses;
    insn_addr = ia; norm_en = en; rw = w; norm_addr = na; norm_wdata = wd;
    @(negedge clk);
    misses = 0;
    if (!in_win(ia)) begin m_insn = '0; misses++; end
    else if (en && w && in_win(na) && widx(na) == widx(ia)) m_insn = wd;
    else m_insn = m_mem[widx(ia)];
    if (en) begin
      if (!in_win(na)) misses++;
      if (!w) m_norm = in_win(na) ? m_mem[widx(na)] : '0;
      else if (in_win(na)) m_mem[widx(na)] = wd;
    end
    if (misses > 0) m_err = 1'b1;
    m_cnt = (m_cnt + misses > 255) ? 255 : m_cnt + misses;
    insn_addr = BASE; norm_en = 1'b0; rw = 1'b0;
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin k = i; break; end
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_miss);
    if (!allow_miss || $urandom_range(0, 3) != 0) return BASE + $urandom_range(0, DEPTH - 1);
    case ($urandom_range(0, 3))
      0: return BASE - 32'($urandom_range(1, 8));
      1: return BASE + 32'(DEPTH) + 32'($urandom_range(0, 8));
      2: return 32'h0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic test_reset();
    int k;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++; if (insn_data !== 32'h0) begin fails++; $display("FAIL reset_insn_data: got %h expected 0", insn_data); end
    tests++; if (norm_rdata !== 32'h0) begin fails++; $display("FAIL reset_norm_rdata: got %h expected 0", norm_rdata); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin k = i; break; end
      if (i == 2) begin
        // write to BASE and an out-of-window fetch while clearing
        norm_en = 1'b1; rw = 1'b1; norm_addr = BASE; norm_wdata = 32'h1; insn_addr = 32'h9999;
      end else if (i == 3) begin
        norm_en = 1'b0; rw = 1'b0; insn_addr = BASE;
      end else if (i == 4) begin
        tests++; if (insn_data !== 32'h0) begin fails++; $display("FAIL clear_insn_zero: got %h expected 0", insn_data); end
      end
    end
    tests++; if (k != DEPTH + 1) begin fails++; $display("FAIL ready_latency: got %0d expected %0d", k, DEPTH + 1); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL clear_no_err: got %0d expected 0", err_count); end
    tests++; if (insn_data !== FILL) begin fails++; $display("FAIL first_fetch: got %h expected %h", insn_data, FILL); end
    model_init();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(BASE + 32'(i), 1'b0, 1'b0, '0, '0);
      tests++; if (insn_data !== FILL) begin fails++; $display("FAIL fill_fetch[%0d]: got %h expected %h", i, insn_data, FILL); end
    end
    step(BASE, 1'b1, 1'b0, BASE, '0);
    tests++; if (norm_rdata !== m_norm) begin fails++; $display("FAIL clear_write_dropped: got %h expected %h", norm_rdata, m_norm); end
  endtask

  task automatic test_write_read();
    step(BASE, 1'b1, 1'b1, 32'h105, 32'h12345678);
    tests++; if (norm_rdata !== FILL) begin fails++; $display("FAIL write_holds_rdata: got %h expected %h", norm_rdata, FILL); end
    step(BASE, 1'b1, 1'b0, 32'h105, '0);
    tests++; if (norm_rdata !== 32'h12345678) begin fails++; $display("FAIL write_then_read: got %h expected 12345678", norm_rdata); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL write_read_err: got %b expected 0", err); end
  endtask

  task automatic test_collision();
    step(32'h107, 1'b1, 1'b1, 32'h107, 32'hCAFEF00D);
    tests++; if (insn_data !== 32'hCAFEF00D) begin fails++; $display("FAIL collision_bypass: got %h expected cafef00d", insn_data); end
    step(32'h107, 1'b0, 1'b0, '0, '0);
    tests++; if (insn_data !== 32'hCAFEF00D) begin fails++; $display("FAIL collision_stored: got %h expected cafef00d", insn_data); end
  endtask

  task automatic test_random(input bit allow_miss, input int n);
    logic [31:0] ia, na, wd;
    logic en, w;
    for (int i = 0; i < n; i++) begin
      ia = rand_addr(allow_miss);
      na = rand_addr(allow_miss);
      wd = $urandom;
      en = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      step(ia, en, w, na, wd);
      tests++; if (insn_data !== m_insn) begin fails++; $display("FAIL rand_insn[%0d]: got %h expected %h", i, insn_data, m_insn); end
      tests++; if (norm_rdata !== m_norm) begin fails++; $display("FAIL rand_norm[%0d]: got %h expected %h", i, norm_rdata, m_norm); end
      tests++; if (err_count !== 8'(m_cnt) || err !== m_err) begin
        fails++; $display("FAIL rand_err[%0d]: got %b/%0d expected %b/%0d", i, err, err_count, m_err, m_cnt);
      end
    end
  endtask

  task automatic test_misses();
    step(32'h200, 1'b1, 1'b0, 32'h0FF, '0);
    tests++; if (insn_data !== 32'h0) begin fails++; $display("FAIL miss_insn: got %h expected 0", insn_data); end
    tests++; if (norm_rdata !== 32'h0) begin fails++; $display("FAIL miss_norm: got %h expected 0", norm_rdata); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL miss_err: got %b expected 1", err); end
    tests++; if (err_count !== 8'd2) begin fails++; $display("FAIL miss_count2: got %0d expected 2", err_count); end
    for (int i = 0; i < 300; i++) step(32'h200, 1'b0, 1'b0, '0, '0);
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL miss_saturate: got %0d expected 255", err_count); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_midclear();
    int k;
    step(BASE, 1'b1, 1'b1, BASE + 32'd3, 32'h5555_AAAA);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL midclear_ready: got %b expected 0", ready); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL midclear_cnt: got %0d expected 0", err_count); end
    reset = 1'b0;
    wait_ready(k);
    tests++; if (k != DEPTH + 1) begin fails++; $display("FAIL midclear_latency: got %0d expected %0d", k, DEPTH + 1); end
    model_init();
    step(BASE, 1'b1, 1'b0, BASE + 32'd3, '0);
    tests++; if (norm_rdata !== FILL) begin fails++; $display("FAIL midclear_recleared: got %h expected %h", norm_rdata, FILL); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_collision();
    test_random(1'b0, 200);
    test_misses();
    test_midclear();
    test_random(1'b1, 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
